// File: rtl/lcd_text_writer_pkg.sv
// rtl/lcd_text_writer_pkg.sv - shared states, LCD command bytes and frame geometry
package lcd_pkg;

  typedef enum logic [2:0] {PWR_WAIT, INIT, CONFIG, IDLE, FRAME} state_t;

  localparam logic [7:0] FUNC_SET = 8'h28;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;
  localparam logic [7:0] SPACE    = 8'h20;

  localparam int NCHAR    = 20;
  localparam int LINE_LEN = 16;
  localparam int NBYTES   = NCHAR + 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_text_writer_if.sv
// rtl/lcd_text_writer_if.sv - HD44780 4-bit write bus
interface lcd_text_writer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [3:0] lcd_d;

  modport master (output lcd_rs, output lcd_rw, output lcd_e, output lcd_d);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_e, input  lcd_d);
endinterface

// File: rtl/lcd_text_writer_nibble_tx.sv
// rtl/lcd_text_writer_nibble_tx.sv - one nibble strobe: setup, E pulse, hold
module lcd_nibble_tx #(
  parameter int SETUP_CYC  = 4,
  parameter int ENABLE_CYC = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic       done,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       lcd_rs
);

  localparam int LEN = 2 * SETUP_CYC + ENABLE_CYC;
  localparam int CW  = $clog2(LEN + 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;
  assign done    = active && (cnt == CW'(LEN - 1));

  // start wins over done so the low nibble can follow the high one back-to-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_d  <= 4'h0;
      lcd_rs <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_d  <= nib;
      lcd_rs <= rs;
    end else if (done) begin
      active <= 1'b0;
      lcd_e  <= 1'b0;
    end else if (active) begin
      cnt   <= cnt_inc;
      lcd_e <= (cnt_inc >= CW'(SETUP_CYC)) && (cnt_inc < CW'(SETUP_CYC + ENABLE_CYC));
    end
  end

endmodule

// File: rtl/lcd_text_writer.sv
// rtl/lcd_text_writer.sv - LCD init sequencer and change-driven 20-char frame writer
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int INIT_WAIT_CYC  = 250000,
  parameter int SETUP_CYC      = 4,
  parameter int ENABLE_CYC     = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [160:0]              txt,
  lcd_text_writer_if.master         lcd,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int WMAX = max_int(max_int(POWERUP_CYC, INIT_WAIT_CYC),
                                max_int(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int WW   = $clog2(WMAX + 1);

  state_t          state, state_n;
  logic [4:0]      idx, idx_n;
  logic            lo, lo_n;
  logic            waiting, waiting_n;
  logic [WW-1:0]   wcnt, wcnt_n, wait_len;
  logic [159:0]    snap, shadow;
  logic            shadow_ok;
  logic            start, latch, finish, is_last, tx_done, tx_rs;
  logic [3:0]      tx_nib;
  logic [8:0]      sel;
  logic            unused_txt_msb;

  assign unused_txt_msb = txt[160];
  assign busy           = (state != IDLE);
  assign lcd.lcd_rw     = 1'b0;

  // {rs, byte} for step i of a phase; INIT entries carry their nibble in the high half
  function automatic logic [8:0] seq_byte(input state_t st, input logic [4:0] i,
                                          input logic [159:0] s);
    logic [7:0] c;
    int         ci;
    seq_byte = {1'b0, SPACE};
    case (st)
      INIT:    seq_byte = {1'b0, (i == 5'd3) ? 8'h22 : 8'h33};
      CONFIG:  case (i)
                 5'd0:    seq_byte = {1'b0, FUNC_SET};
                 5'd1:    seq_byte = {1'b0, DISP_ON};
                 5'd2:    seq_byte = {1'b0, ENTRY};
                 default: seq_byte = {1'b0, CLEAR};
               endcase
      FRAME: begin
        if (i == 5'd0) begin
          seq_byte = {1'b0, LINE1};
        end else if (int'(i) == LINE_LEN + 1) begin
          seq_byte = {1'b0, LINE2};
        end else begin
          ci = (int'(i) <= LINE_LEN) ? int'(i) - 1 : int'(i) - 2;
          c  = s[8*ci +: 8];
          seq_byte = {1'b1, (c == 8'h00) ? SPACE : c};
        end
      end
      default: seq_byte = {1'b0, SPACE};
    endcase
  endfunction

  always_comb begin
    wait_len = WW'(CMD_WAIT_CYC);
    if (state == INIT && idx == 5'd0)
      wait_len = WW'(INIT_WAIT_CYC);
    else if (state == CONFIG && idx == 5'd3)
      wait_len = WW'(CLEAR_WAIT_CYC);
    is_last = (state == FRAME) ? (idx == 5'(NBYTES - 1)) : (idx == 5'd3);
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    lo_n      = lo;
    waiting_n = waiting;
    wcnt_n    = wcnt;
    start     = 1'b0;
    latch     = 1'b0;
    finish    = 1'b0;
    case (state)
      PWR_WAIT: begin
        if (wcnt == WW'(1)) begin
          state_n = INIT;
          idx_n   = '0;
          start   = 1'b1;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
      IDLE: begin
        if (!shadow_ok || (txt[159:0] != shadow)) begin
          state_n = FRAME;
          idx_n   = '0;
          lo_n    = 1'b0;
          latch   = 1'b1;
          start   = 1'b1;
        end
      end
      default: begin
        if (waiting) begin
          if (wcnt == WW'(1)) begin
            waiting_n = 1'b0;
            if (!is_last) begin
              idx_n = idx + 5'd1;
              start = 1'b1;
            end else if (state == INIT) begin
              state_n = CONFIG;
              idx_n   = '0;
              start   = 1'b1;
            end else begin
              state_n = IDLE;
              finish  = (state == FRAME);
            end
          end else begin
            wcnt_n = wcnt - 1'b1;
          end
        end else if (tx_done) begin
          if (state != INIT && !lo) begin
            lo_n  = 1'b1;
            start = 1'b1;
          end else begin
            lo_n      = 1'b0;
            waiting_n = 1'b1;
            wcnt_n    = wait_len;
          end
        end
      end
    endcase
    sel    = seq_byte(state_n, idx_n, snap);
    tx_nib = lo_n ? sel[3:0] : sel[7:4];
    tx_rs  = sel[8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PWR_WAIT;
      idx        <= '0;
      lo         <= 1'b0;
      waiting    <= 1'b0;
      wcnt       <= WW'(POWERUP_CYC);
      snap       <= '0;
      shadow     <= '0;
      shadow_ok  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      lo         <= lo_n;
      waiting    <= waiting_n;
      wcnt       <= wcnt_n;
      frame_done <= finish;
      if (latch)
        snap <= txt[159:0];
      if (finish) begin
        shadow    <= snap;
        shadow_ok <= 1'b1;
      end
    end
  end

  lcd_nibble_tx #(
    .SETUP_CYC  (SETUP_CYC),
    .ENABLE_CYC (ENABLE_CYC)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .nib    (tx_nib),
    .rs     (tx_rs),
    .done   (tx_done),
    .lcd_e  (lcd.lcd_e),
    .lcd_d  (lcd.lcd_d),
    .lcd_rs (lcd.lcd_rs)
  );

endmodule

// File: tb/tb_lcd_text_writer.sv
// tb/tb_lcd_text_writer.sv - randomized self-checking bench for lcd_text_writer
module tb_lcd_text_writer;

  localparam int P_PWR = 10, P_IW = 6, P_SU = 1, P_EN = 2, P_CMD = 3, P_CLR = 5;
  localparam int FRAME_LEN = 22 * (2 * (2 * P_SU + P_EN) + P_CMD);
  localparam logic [160:0] WELCOME  = {17'd0, " :SREYALP .EMOCLEW"};
  localparam logic [160:0] STARTING = {33'd0, " :EULAV GNITRATS"};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [160:0] txt = WELCOME;
  logic         busy, frame_done;
  int           checks = 0, failures = 0;
  int           cyc = 0;

  lcd_text_writer_if lcd();

  lcd_text_writer #(
    .POWERUP_CYC(P_PWR), .INIT_WAIT_CYC(P_IW), .SETUP_CYC(P_SU),
    .ENABLE_CYC(P_EN), .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .clk(clk), .reset(reset), .txt(txt), .lcd(lcd),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // bus monitor: one entry per E rise, plus frame_done and busy edges
  logic       e_prev = 1'b0, busy_prev = 1'b1;
  int         fd_cnt = 0, fd_cyc = 0, busy_rise_cyc = 0;
  logic [4:0] nq[$];
  int         tq[$];

  always @(negedge clk) begin
    if (lcd.lcd_e && !e_prev) begin
      nq.push_back({lcd.lcd_rs, lcd.lcd_d});
      tq.push_back(cyc);
    end
    e_prev = lcd.lcd_e;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    busy_prev = busy;
  end

  task automatic wait_nibbles(input int n, input int budget, output bit ok);
    int k = 0;
    while (nq.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    ok = (nq.size() >= n);
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    int k = 0;
    while (fd_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    ok = (fd_cnt >= target);
  endtask

  task automatic pop_nib(output logic [4:0] n);
    if (nq.size() > 0) begin
      n = nq.pop_front();
      void'(tq.pop_front());
    end else begin
      n = 5'bx;
    end
  endtask

  task automatic pop_frame(output logic [8:0] got[22]);
    logic [4:0] h, l;
    for (int k = 0; k < 22; k++) begin
      pop_nib(h);
      pop_nib(l);
      got[k] = (h[4] === l[4]) ? {h[4], h[3:0], l[3:0]} : 9'bx;
    end
  endtask

  // reference frame: address line 1, 16 chars, address line 2, 4 chars; NUL shows as space
  task automatic model_frame(input logic [160:0] t, output logic [8:0] f[22]);
    logic [8:0] q[$];
    logic [7:0] ch[20];
    for (int i = 0; i < 20; i++) begin
      ch[i] = t[8*i +: 8];
      if (ch[i] == 8'h00) ch[i] = 8'h20;
    end
    q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) q.push_back({1'b1, ch[i]});
    q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 20; i++) q.push_back({1'b1, ch[i]});
    for (int k = 0; k < 22; k++) f[k] = q[k];
  endtask

  function automatic logic [160:0] rand_txt(input logic [160:0] prev);
    logic [160:0] t;
    for (int i = 0; i < 20; i++)
      t[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
    t[160] = 1'($urandom_range(0, 1));
    if (t[159:0] == prev[159:0]) t[7:0] = ~t[7:0];
    return t;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (lcd.lcd_e !== 1'b0) begin failures++; $display("FAIL reset_e got=%b exp=0", lcd.lcd_e); end
    checks++; if (lcd.lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b exp=0", lcd.lcd_rs); end
    checks++; if (lcd.lcd_rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", lcd.lcd_rw); end
    checks++; if (lcd.lcd_d !== 4'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", lcd.lcd_d); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_init();
    logic [4:0] exp_n[12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                              5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
    logic [4:0] n;
    bit ok;
    int rel, first, gap_cmd, gap_clr;
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    wait_nibbles(13, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL init_timeout got=%0d nibbles exp=13", nq.size()); end
    first   = (tq.size() > 0)  ? tq[0] - rel     : -1;
    gap_cmd = (tq.size() > 10) ? tq[10] - tq[9]  : -1;
    gap_clr = (tq.size() > 12) ? tq[12] - tq[11] : -1;
    checks++; if (first != P_PWR + P_SU) begin failures++; $display("FAIL init_first_rise got=%0d exp=%0d", first, P_PWR + P_SU); end
    checks++; if (gap_cmd != P_EN + P_SU + P_CMD + P_SU) begin failures++; $display("FAIL init_cmd_gap got=%0d exp=%0d", gap_cmd, P_EN + 2 * P_SU + P_CMD); end
    checks++; if (gap_clr != P_EN + P_SU + P_CLR + 1 + P_SU) begin failures++; $display("FAIL init_clear_gap got=%0d exp=%0d", gap_clr, P_EN + 2 * P_SU + P_CLR + 1); end
    for (int i = 0; i < 12; i++) begin
      pop_nib(n);
      checks++;
      if (n !== exp_n[i]) begin failures++; $display("FAIL init_nib%0d got=%h exp=%h", i, n, exp_n[i]); end
    end
  endtask

  task automatic test_welcome_frame();
    logic [8:0] got[22], exp[22];
    bit ok;
    wait_fd(1, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL welcome_timeout got=%0d exp=1", fd_cnt); end
    model_frame(WELCOME, exp);
    pop_frame(got);
    for (int k = 0; k < 22; k++) begin
      checks++;
      if (got[k] !== exp[k]) begin failures++; $display("FAIL welcome_byte%0d got=%h exp=%h", k, got[k], exp[k]); end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL welcome_fd_count got=%0d exp=1", fd_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL welcome_busy got=%b exp=0", busy); end
  endtask

  task automatic test_steady_bus();
    int fd0 = fd_cnt;
    repeat (1000) @(negedge clk);
    #1;
    checks++; if (nq.size() != 0) begin failures++; $display("FAIL steady_e_activity got=%0d exp=0", nq.size()); end
    checks++; if (fd_cnt != fd0) begin failures++; $display("FAIL steady_fd got=%0d exp=%0d", fd_cnt, fd0); end
  endtask

  task automatic test_random_frames();
    logic [8:0] got[22], exp[22];
    logic [160:0] nt;
    bit ok;
    int c0, fd0, lat, e_lat, dur;
    for (int r = 0; r < 4; r++) begin
      nt = rand_txt(txt);
      @(negedge clk);
      txt = nt;
      c0 = cyc;
      fd0 = fd_cnt;
      wait_fd(fd0 + 1, 1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_timeout got=%0d exp=%0d", r, fd_cnt, fd0 + 1); end
      lat   = busy_rise_cyc - c0;
      e_lat = (tq.size() > 0) ? tq[0] - busy_rise_cyc : -1;
      dur   = fd_cyc - busy_rise_cyc;
      checks++; if (lat != 1) begin failures++; $display("FAIL rand%0d_start_latency got=%0d exp=1", r, lat); end
      checks++; if (e_lat != P_SU) begin failures++; $display("FAIL rand%0d_first_e got=%0d exp=%0d", r, e_lat, P_SU); end
      checks++; if (dur != FRAME_LEN) begin failures++; $display("FAIL rand%0d_frame_len got=%0d exp=%0d", r, dur, FRAME_LEN); end
      model_frame(nt, exp);
      pop_frame(got);
      for (int k = 0; k < 22; k++) begin
        checks++;
        if (got[k] !== exp[k]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", r, k, got[k], exp[k]); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand%0d_busy got=%b exp=0", r, busy); end
    end
  endtask

  task automatic test_midframe_change();
    logic [8:0] got[22], exp[22];
    logic [160:0] old_t;
    bit ok;
    int fd0 = fd_cnt;
    old_t = rand_txt(txt);
    @(negedge clk);
    txt = old_t;
    wait_nibbles(13, 500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_reach_char5 got=%0d exp=13", nq.size()); end
    txt = STARTING;
    wait_fd(fd0 + 2, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=%0d exp=%0d", fd_cnt, fd0 + 2); end
    model_frame(old_t, exp);
    pop_frame(got);
    for (int k = 0; k < 22; k++) begin
      checks++;
      if (got[k] !== exp[k]) begin failures++; $display("FAIL mid_old_byte%0d got=%h exp=%h", k, got[k], exp[k]); end
    end
    model_frame(STARTING, exp);
    pop_frame(got);
    for (int k = 0; k < 22; k++) begin
      checks++;
      if (got[k] !== exp[k]) begin failures++; $display("FAIL mid_new_byte%0d got=%h exp=%h", k, got[k], exp[k]); end
    end
    repeat (300) @(negedge clk);
    #1;
    checks++; if (fd_cnt != fd0 + 2) begin failures++; $display("FAIL mid_frame_count got=%0d exp=%0d", fd_cnt, fd0 + 2); end
    checks++; if (nq.size() != 0) begin failures++; $display("FAIL mid_extra_nibbles got=%0d exp=0", nq.size()); end
  endtask

  task automatic test_ignored_bit();
    int fd0 = fd_cnt;
    @(negedge clk);
    txt[160] = ~txt[160];
    repeat (300) @(negedge clk);
    #1;
    checks++; if (nq.size() != 0) begin failures++; $display("FAIL bit160_nibbles got=%0d exp=0", nq.size()); end
    checks++; if (fd_cnt != fd0) begin failures++; $display("FAIL bit160_fd got=%0d exp=%0d", fd_cnt, fd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bit160_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midpulse();
    logic [4:0] exp_n[4] = '{5'h03, 5'h03, 5'h03, 5'h02};
    logic [4:0] n;
    bit ok, seen;
    int k, rel, first;
    @(negedge clk);
    txt = rand_txt(txt);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      @(negedge clk);
      seen = lcd.lcd_e;
      k++;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rstmid_no_pulse got=0 exp=1"); end
    #1 reset = 1'b1;
    #1;
    checks++; if (lcd.lcd_e !== 1'b0) begin failures++; $display("FAIL rstmid_e_async got=%b exp=0", lcd.lcd_e); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
    checks++; if (lcd.lcd_d !== 4'h0) begin failures++; $display("FAIL rstmid_d got=%h exp=0", lcd.lcd_d); end
    repeat (2) @(negedge clk);
    nq.delete();
    tq.delete();
    reset = 1'b0;
    rel = cyc;
    wait_nibbles(4, 500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got=%0d exp=4", nq.size()); end
    first = (tq.size() > 0) ? tq[0] - rel : -1;
    checks++; if (first != P_PWR + P_SU) begin failures++; $display("FAIL rstmid_first_rise got=%0d exp=%0d", first, P_PWR + P_SU); end
    for (int i = 0; i < 4; i++) begin
      pop_nib(n);
      checks++;
      if (n !== exp_n[i]) begin failures++; $display("FAIL rstmid_nib%0d got=%h exp=%h", i, n, exp_n[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_welcome_frame();
    test_steady_bus();
    test_random_frames();
    test_midframe_change();
    test_ignored_bit();
    test_reset_midpulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
